// File: rtl/min_max_pkg.sv
// Shared types for the min/max LED bar controller and its datapath reference model.
package min_max_pkg;

  typedef enum logic [1:0] {
    COM_NORMAL  = 2'b00,
    COM_LINEAR  = 2'b01,
    COM_ALL_OFF = 2'b10,
    COM_ALL_ON  = 2'b11
  } com_t;

  typedef enum logic [1:0] {
    RUN,
    LAMP_ON,
    LAMP_OFF
  } ctrl_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/min_max_osc_gen.sv
// Free-running square wave: toggles every OSC_DIV cycles, independent of everything else.
module min_max_osc_gen
  import min_max_pkg::*;
#(
  parameter int OSC_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic osc_o
);

  localparam int CW = cnt_width(OSC_DIV);
  localparam logic [CW-1:0] LAST = CW'(OSC_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt   <= '0;
      osc_o <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      osc_o <= ~osc_o;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/min_max_ctrl.sv
// Sequencer for the min/max LED bar datapath: validated configuration intake,
// on-demand lamp test (all ON then all OFF) and the low-intensity oscillator.
module min_max_ctrl
  import min_max_pkg::*;
#(
  parameter int VALSIZE     = 4,
  parameter int OSC_DIV     = 4,
  parameter int LAMP_CYCLES = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [1:0]         cfg_com_i,
  input  logic [VALSIZE-1:0] cfg_min_i,
  input  logic [VALSIZE-1:0] cfg_max_i,
  input  logic [VALSIZE-1:0] cfg_val_i,
  input  logic               lamp_test_i,
  output logic               busy_o,
  output logic               cfg_err_o,
  output logic [1:0]         com_o,
  output logic [VALSIZE-1:0] min_o,
  output logic [VALSIZE-1:0] max_o,
  output logic [VALSIZE-1:0] val_o,
  output logic               osc_o
);

  localparam int PW = cnt_width(LAMP_CYCLES);
  localparam logic [PW-1:0] PHASE_LAST = PW'(LAMP_CYCLES - 1);

  ctrl_state_t   state;
  logic [PW-1:0] phase;
  com_t          mode;

  logic accept;
  logic reject;
  logic store;

  assign accept = cfg_valid_i && cfg_ready_o;
  // Inverted bounds are only meaningful to reject in normal mode.
  assign reject = (cfg_com_i == COM_NORMAL) && (cfg_min_i > cfg_max_i);
  assign store  = accept && !reject;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= RUN;
      phase       <= '0;
      mode        <= COM_NORMAL;
      com_o       <= COM_NORMAL;
      min_o       <= '0;
      max_o       <= '1;
      val_o       <= '0;
      cfg_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      cfg_err_o   <= 1'b0;
    end else begin
      if (accept) begin
        cfg_err_o <= reject;
        if (!reject) begin
          mode  <= com_t'(cfg_com_i);
          min_o <= cfg_min_i;
          max_o <= cfg_max_i;
          val_o <= cfg_val_i;
        end
      end

      case (state)
        RUN: begin
          if (lamp_test_i) begin
            state       <= LAMP_ON;
            phase       <= '0;
            com_o       <= COM_ALL_ON;
            busy_o      <= 1'b1;
            cfg_ready_o <= 1'b0;
          end else begin
            com_o       <= store ? cfg_com_i : mode;
            busy_o      <= 1'b0;
            cfg_ready_o <= 1'b1;
          end
        end
        LAMP_ON: begin
          if (phase == PHASE_LAST) begin
            state <= LAMP_OFF;
            phase <= '0;
            com_o <= COM_ALL_OFF;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        LAMP_OFF: begin
          if (phase == PHASE_LAST) begin
            state       <= RUN;
            phase       <= '0;
            com_o       <= mode;
            busy_o      <= 1'b0;
            cfg_ready_o <= 1'b1;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  min_max_osc_gen #(.OSC_DIV(OSC_DIV)) u_osc (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .osc_o(osc_o)
  );

endmodule

// File: tb/tb_min_max_ctrl.sv
// Self-checking bench for min_max_ctrl: vector table, hand sequences and a random run
// compared against an edge-counting reference model.
module tb_min_max_ctrl;

  localparam int VS = 4;
  localparam int OD = 4;
  localparam int L  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_com = 2'b00;
  logic [VS-1:0] cfg_min = '0;
  logic [VS-1:0] cfg_max = '0;
  logic [VS-1:0] cfg_val = '0;
  logic          lamp_test = 1'b0;
  logic          busy;
  logic          cfg_err;
  logic [1:0]    com;
  logic [VS-1:0] min_v, max_v, val_v;
  logic          osc;

  always #5 clk = ~clk;

  min_max_ctrl #(.VALSIZE(VS), .OSC_DIV(OD), .LAMP_CYCLES(L)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_com_i(cfg_com), .cfg_min_i(cfg_min), .cfg_max_i(cfg_max), .cfg_val_i(cfg_val),
    .lamp_test_i(lamp_test), .busy_o(busy), .cfg_err_o(cfg_err),
    .com_o(com), .min_o(min_v), .max_o(max_v), .val_o(val_v), .osc_o(osc)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: e counts rising edges since reset release; a lamp test started
  // at edge lamp_s occupies the cycles after edges lamp_s .. lamp_s+2L-1.
  int   e;
  int   lamp_s;
  int   s_com, s_min, s_max, s_val;
  bit   m_err, m_ready;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic model_reset();
    e = 0; lamp_s = -1000;
    s_com = 0; s_min = 0; s_max = (1 << VS) - 1; s_val = 0;
    m_err = 1'b0; m_ready = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_com", int'(com), 0);
    chk("rst_min", int'(min_v), 0);
    chk("rst_max", int'(max_v), (1 << VS) - 1);
    chk("rst_val", int'(val_v), 0);
    chk("rst_osc", int'(osc), 0);
    chk("rst_ready", int'(cfg_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(cfg_err), 0);
  endtask

  task automatic step();
    bit run_before, acc, lamp_now;
    int exp_com;
    @(posedge clk);
    e++;
    run_before = !((e - 1) >= lamp_s && (e - 1) <= lamp_s + 2 * L - 1);
    acc = cfg_valid && m_ready;
    if (acc) begin
      if (cfg_com == 2'b00 && cfg_min > cfg_max) m_err = 1'b1;
      else begin
        s_com = int'(cfg_com); s_min = int'(cfg_min);
        s_max = int'(cfg_max); s_val = int'(cfg_val);
        m_err = 1'b0;
      end
    end
    if (run_before && lamp_test) lamp_s = e;
    #1;
    lamp_now = (e >= lamp_s) && (e <= lamp_s + 2 * L - 1);
    exp_com  = lamp_now ? ((e - lamp_s < L) ? 3 : 2) : s_com;
    m_ready  = !lamp_now;
    chk("com", int'(com), exp_com);
    chk("min", int'(min_v), s_min);
    chk("max", int'(max_v), s_max);
    chk("val", int'(val_v), s_val);
    chk("err", int'(cfg_err), int'(m_err));
    chk("ready", int'(cfg_ready), int'(m_ready));
    chk("busy", int'(busy), int'(lamp_now));
    chk("osc", int'(osc), (e / OD) % 2);
  endtask

  task automatic drive(input bit v, input int c, input int mn, input int mx, input int vl, input bit lt);
    cfg_valid = v; cfg_com = 2'(c); cfg_min = VS'(mn); cfg_max = VS'(mx); cfg_val = VS'(vl);
    lamp_test = lt;
  endtask

  typedef struct {
    int c, mn, mx, vl;
    int e_com, e_min, e_max, e_val, e_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int g, low_cnt;

    vecs[0] = '{0, 3, 12, 8,   0, 3, 12, 8, 0};
    vecs[1] = '{0, 12, 3, 5,   0, 3, 12, 8, 1};
    vecs[2] = '{1, 0, 15, 4,   1, 0, 15, 4, 0};
    vecs[3] = '{0, 5, 5, 9,    0, 5, 5, 9, 0};
    vecs[4] = '{2, 9, 2, 1,    2, 9, 2, 1, 0};
    vecs[5] = '{0, 0, 15, 0,   0, 0, 15, 0, 0};

    model_reset();
    #2 rst = 1'b1;
    #3 check_reset_values();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();
    step();

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].c, vecs[i].mn, vecs[i].mx, vecs[i].vl, 1'b0);
      step();
      chk("vec_com", int'(com), vecs[i].e_com);
      chk("vec_min", int'(min_v), vecs[i].e_min);
      chk("vec_max", int'(max_v), vecs[i].e_max);
      chk("vec_val", int'(val_v), vecs[i].e_val);
      chk("vec_err", int'(cfg_err), vecs[i].e_err);
      $display("vector %0d: com=%0d min=%0d max=%0d val=%0d err=%0d", i,
               com, min_v, max_v, val_v, cfg_err);
      drive(1'b0, 0, 0, 0, 0, 1'b0);
      step();
    end

    // Lamp test with a configuration held across it.
    drive(1'b0, 0, 0, 0, 0, 1'b1);
    step();
    low_cnt = (cfg_ready == 1'b0) ? 1 : 0;
    drive(1'b1, 1, 2, 7, 3, 1'b0);
    g = 0;
    while (busy && g < 40) begin
      step();
      if (cfg_ready == 1'b0) low_cnt++;
      g++;
    end
    chk("lamp_done", int'(busy), 0);
    chk("ready_low_cycles", low_cnt, 2 * L);
    step();
    chk("held_cfg_com", int'(com), 1);
    chk("held_cfg_val", int'(val_v), 3);
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    step();
    $display("lamp test with held transfer: ready low for %0d cycles", low_cnt);

    // Transfer and lamp request on the same edge.
    drive(1'b1, 3, 0, 15, 0, 1'b1);
    step();
    chk("simul_com_on", int'(com), 3);
    chk("simul_busy", int'(busy), 1);
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    repeat (2 * L) step();
    chk("simul_after_com", int'(com), 3);
    chk("simul_after_ready", int'(cfg_ready), 1);
    $display("simultaneous transfer+lamp: com=%0d", com);

    // Reset in the middle of LAMP_OFF.
    drive(1'b0, 0, 0, 0, 0, 1'b1);
    step();
    lamp_test = 1'b0;
    repeat (L + 3) step();
    chk("pre_rst_com_off", int'(com), 2);
    #2 rst = 1'b1;
    #1 check_reset_values();
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();
    chk("post_rst_ready", int'(cfg_ready), 1);
    chk("post_rst_busy", int'(busy), 0);
    $display("reset during LAMP_OFF: outputs cleared");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), ($urandom_range(0, 24) == 0));
      step();
    end
    drive(1'b0, 0, 0, 0, 0, 1'b0);
    repeat (2 * L + 2) step();
    $display("random run: %0d cycles", 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
